bf16_to_int: RTL and testbench

- Downstream consumer of the bfloat16 adder.
- Converts each completed 16-bit bfloat16 sum (1 sign, 8 exponent bias 127, 7 mantissa) to a saturating signed two's-complement integer.
- Captures on the adder's ready rising edge, shifts iteratively (one bit per cycle), rounds to nearest-even, then holds the result on a valid/ready output handshake.

---
 rtl/bf16_to_int.sv | 185 ++++++++++++++++++
 tb/tb_bf16_to_int.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_to_int.sv
// rtl/bf16_to_int.sv - bfloat16 to saturating signed integer converter, iterative shift, round-to-nearest-even
// Optional status outputs (ovf, invalid, inexact) are enabled by defining BF16_TO_INT_STATUS_EN.
module bf16_to_int #(
    parameter int OUT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             busy,
    output logic             dropped,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready
`ifdef BF16_TO_INT_STATUS_EN
    ,
    output logic             ovf,
    output logic             invalid,
    output logic             inexact
`endif
);

    localparam int ACC_W = OUT_W + 8;
    localparam int CNT_W = $clog2(OUT_W);
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [9:0] E_SAT  = 10'(OUT_W - 1);

    typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               prev_valid;
    logic               rise;
    logic [15:0]        op;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               special;
    logic [OUT_W-1:0]   special_res;

    logic               sign;
    logic [7:0]         expo;
    logic [6:0]         man;
    logic signed [9:0]  e;
    logic               dec_zero;
    logic               dec_nan;
    logic               dec_inf;
    logic               dec_big;
    logic               dec_exact_min;
    logic               dec_special;

    logic [OUT_W:0]     mag_raw;
    logic [OUT_W:0]     mag_rnd;
    logic [OUT_W:0]     mag_neg;
    logic               guard;
    logic               sticky;
    logic               round_sat;
    logic [OUT_W-1:0]   round_res;

    assign rise = in_valid & ~prev_valid;
    assign busy = (state != IDLE);

    assign sign          = op[15];
    assign expo          = op[14:7];
    assign man           = op[6:0];
    assign e             = $signed({2'b00, expo}) - 10'sd127;
    assign dec_zero      = (expo == 8'd0);
    assign dec_nan       = (expo == 8'hFF) && (man != 7'd0);
    assign dec_inf       = (expo == 8'hFF) && (man == 7'd0);
    assign dec_big       = !dec_zero && (expo != 8'hFF) && (e >= E_SAT);
    assign dec_exact_min = dec_big && sign && (e == E_SAT) && (man == 7'd0);
    assign dec_special   = dec_zero | dec_nan | dec_inf | dec_big;

    // acc holds the value with 7 fraction bits; everything below the guard bit folds into sticky
    assign mag_raw   = acc[ACC_W-1:7];
    assign guard     = acc[6];
    assign sticky    = |acc[5:0];
    assign mag_rnd   = mag_raw + (OUT_W+1)'(guard & (sticky | mag_raw[0]));
    assign mag_neg   = ~mag_rnd + (OUT_W+1)'(1);
    assign round_sat = !sign && (mag_rnd > {1'b0, POS_MAX});
    assign round_res = round_sat ? POS_MAX : (sign ? mag_neg[OUT_W-1:0] : mag_rnd[OUT_W-1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = DECODE;
            DECODE:  state_nxt = dec_special ? ROUND : SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_valid  <= 1'b0;
            dropped     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            op          <= '0;
            acc         <= '0;
            cnt         <= '0;
            special     <= 1'b0;
            special_res <= '0;
        end else begin
            prev_valid <= in_valid;
            if (rise && state != IDLE) begin
                dropped <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rise) op <= in_data;
                end
                DECODE: begin
                    special     <= dec_special;
                    special_res <= (dec_inf || dec_big) ? (sign ? NEG_MAX : POS_MAX) : '0;
                    cnt         <= '0;
                    acc         <= '0;
                    if (!dec_special) begin
                        if (e < 10'sd0) begin
                            // |x| < 1: preload only the round and sticky positions
                            acc[6] <= (e == -10'sd1);
                            acc[0] <= (e == -10'sd1) ? (man != 7'd0) : 1'b1;
                        end else begin
                            acc <= ACC_W'({1'b1, man});
                            cnt <= e[CNT_W-1:0];
                        end
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc << 1;
                        cnt <= cnt - 1'b1;
                    end
                end
                ROUND: begin
                    out_data  <= special ? special_res : round_res;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef BF16_TO_INT_STATUS_EN
    logic pend_ovf;
    logic pend_inv;
    logic pend_inx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_ovf <= 1'b0;
            pend_inv <= 1'b0;
            pend_inx <= 1'b0;
            ovf      <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            if (state == DECODE) begin
                pend_ovf <= dec_inf | (dec_big & ~dec_exact_min);
                pend_inv <= dec_nan;
                pend_inx <= dec_zero & (man != 7'd0);
            end
            if (state == ROUND) begin
                ovf     <= special ? pend_ovf : round_sat;
                invalid <= pend_inv;
                inexact <= special ? pend_inx : (guard | sticky);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bf16_to_int.sv
// tb/tb_bf16_to_int.sv - scoreboard bench for bf16_to_int with an arithmetic reference model
module tb_bf16_to_int;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data = 16'h0;
    logic         busy;
    logic         dropped;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
`ifdef BF16_TO_INT_STATUS_EN
    logic         ovf;
    logic         invalid;
    logic         inexact;
`endif

    bf16_to_int #(.OUT_W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .dropped   (dropped),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef BF16_TO_INT_STATUS_EN
        ,
        .ovf       (ovf),
        .invalid   (invalid),
        .inexact   (inexact)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] data;
        int           lat;
        int           cap;
        logic         ovf;
        logic         inv;
        logic         inx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rand_ready = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Value = (128+M) * 2^(e-7); round that rational to nearest-even, then clamp.
    function automatic exp_t model(input logic [15:0] x);
        exp_t   r;
        int     s, ex, m, e, sh;
        longint lim, v, n, qv, rem, half;
        s  = int'(x[15]);
        ex = int'(x[14:7]);
        m  = int'(x[6:0]);
        e  = ex - 127;
        lim = longint'(1) << (W - 1);
        r.ovf = 1'b0; r.inv = 1'b0; r.inx = 1'b0; r.cap = 0;
        if (ex == 0) begin
            v = 0; r.inx = (m != 0); r.lat = 2;
        end else if (ex == 255) begin
            r.lat = 2;
            if (m != 0) begin v = 0; r.inv = 1'b1; end
            else begin v = s ? -lim : lim - 1; r.ovf = 1'b1; end
        end else if (e >= W - 1) begin
            r.lat = 2;
            if (s == 1 && e == W - 1 && m == 0) v = -lim;
            else begin v = s ? -lim : lim - 1; r.ovf = 1'b1; end
        end else begin
            r.lat = (e < 0) ? 3 : 3 + e;
            n  = 128 + m;
            sh = 7 - e;
            if (sh >= 9) begin
                qv = 0; rem = n;
            end else if (sh <= 0) begin
                qv = n << (-sh); rem = 0;
            end else begin
                qv   = n >> sh;
                rem  = n - (qv << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && qv % 2 == 1)) qv = qv + 1;
            end
            r.inx = (rem != 0);
            v = s ? -qv : qv;
            if (v > lim - 1) begin v = lim - 1; r.ovf = 1'b1; end
            if (v < -lim)    begin v = -lim;    r.ovf = 1'b1; end
        end
        r.data = W'(v);
        return r;
    endfunction

    logic         ov_q = 1'b0;
    logic         rdy_q = 1'b0;
    logic [W-1:0] hold_q = '0;

    always @(negedge clock) begin
        if (reset) begin
            ov_q = 1'b0;
        end else begin
            if (out_valid && !ov_q) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("out_data", longint'(out_data), longint'(x.data));
                    check("latency", cyc - x.cap, x.lat);
`ifdef BF16_TO_INT_STATUS_EN
                    check("ovf", longint'(ovf), longint'(x.ovf));
                    check("invalid", longint'(invalid), longint'(x.inv));
                    check("inexact", longint'(inexact), longint'(x.inx));
`endif
                end
            end else if (out_valid && ov_q && !rdy_q) begin
                check("hold_data", longint'(out_data), longint'(hold_q));
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            ov_q   = out_valid;
            rdy_q  = out_ready;
            hold_q = out_data;
        end
    end

    task automatic convert(input logic [15:0] d);
        exp_t x;
        int   guard_cnt = 0;
        @(negedge clock);
        while (busy && guard_cnt < 2000) begin
            @(negedge clock);
            guard_cnt++;
        end
        if (busy) check("idle_timeout", 1, 0);
        in_data  = d;
        in_valid = 1'b1;
        x = model(d);
        x.cap = cyc + 1;
        q.push_back(x);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard_cnt = 0;
        while ((q.size() != 0 || out_valid || busy) && guard_cnt < 3000) begin
            @(negedge clock);
            guard_cnt++;
        end
        if (q.size() != 0 || busy) check("drain_timeout", 1, 0);
    endtask

    logic [15:0] plan [11] = '{16'h3F80, 16'hC2F6, 16'h4040, 16'h3FC0, 16'h4020, 16'h3F00,
                               16'h3F40, 16'h4780, 16'hC700, 16'hFF80, 16'h7FC0};

    initial begin
        logic [31:0] r;
        logic [7:0]  ex;
        int          guard_cnt;
        repeat (3) @(negedge clock);
        check("reset_busy", longint'(busy), 0);
        check("reset_dropped", longint'(dropped), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_data", longint'(out_data), 0);
        reset = 1'b0;
        out_ready = 1'b1;

        foreach (plan[i]) convert(plan[i]);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            if (r[31:30] != 2'b00) ex = 8'($urandom_range(115, 145));
            else ex = r[14:7];
            convert({r[15], ex, r[6:0]});
        end
        drain();
        rand_ready = 1'b0;
        @(negedge clock);
        out_ready = 1'b1;
        check("no_spurious_drop", longint'(dropped), 0);

        out_ready = 1'b0;
        convert(16'h3F80);
        guard_cnt = 0;
        while (!out_valid && guard_cnt < 50) begin
            @(negedge clock);
            guard_cnt++;
        end
        repeat (2) @(negedge clock);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("held_out_valid", longint'(out_valid), 1);
        check("held_out_data", longint'(out_data), 1);
        check("dropped_set", longint'(dropped), 1);
        out_ready = 1'b1;
        @(negedge clock);
        check("handoff_out_valid", longint'(out_valid), 0);
        check("handoff_busy", longint'(busy), 0);
        repeat (10) @(negedge clock);
        check("no_second_result", longint'(out_valid), 0);
        check("queue_empty", q.size(), 0);

        convert(16'hC2F6);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        check("rst_busy", longint'(busy), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_dropped", longint'(dropped), 0);
        begin
            exp_t x;
            in_data  = 16'h3F80;
            in_valid = 1'b1;
            x = model(16'h3F80);
            x.cap = cyc + 1;
            q.push_back(x);
            reset = 1'b0;
        end
        @(negedge clock);
        check("capture_after_reset_busy", longint'(busy), 1);
        in_valid = 1'b0;
        drain();
        check("final_out_data", longint'(out_data), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
